// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex driver for a common-anode seven-segment bank: a shadow
// snapshot of the value is scanned one digit per REFRESH_DIV cycles.
module seven_seg_scanner #(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode
);

  localparam int   PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]         prescaler_reg;
  logic [IW-1:0]         index_reg;
  logic [4*DIGITS-1:0]   shadow_value_reg;
  logic [DIGITS-1:0]     shadow_dp_reg;
  logic [6:0]            segments_reg;
  logic                  dp_reg;
  logic [DIGITS-1:0]     anode_reg;

  logic                  wrap;
  logic [DIGITS-1:0]     anode_on;
  logic [DIGITS-1:0]     blank;
  logic [6:0]            digit_seg [DIGITS];
  logic [6:0]            seg_on;
  logic                  dp_on;

  // Glyph table in active-low form, bit order gfedcba.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign wrap = (prescaler_reg == PW'(REFRESH_DIV - 1));

  // Per-digit decode in active-high form; selection is an AND-OR over the one-hot index.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign anode_on[gi] = (index_reg == IW'(gi));
      if (BLANK_LEADING != 0 && gi > 0) begin : g_blank
        assign blank[gi] = (shadow_value_reg[4*DIGITS-1:4*gi] == '0);
      end else begin : g_noblank
        assign blank[gi] = 1'b0;
      end
      assign digit_seg[gi] = blank[gi] ? 7'h00 : ~glyph(shadow_value_reg[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    seg_on = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (anode_on[i]) seg_on = seg_on | digit_seg[i];
    end
    dp_on = |(shadow_dp_reg & anode_on);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg    <= '0;
      index_reg        <= '0;
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      segments_reg     <= {7{POL}};
      dp_reg           <= POL;
      anode_reg        <= {DIGITS{POL}};
    end else begin
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp_in;
      end
      if (wrap) begin
        prescaler_reg <= '0;
        index_reg     <= (index_reg == IW'(DIGITS - 1)) ? '0 : index_reg + IW'(1);
      end else begin
        prescaler_reg <= prescaler_reg + PW'(1);
      end
      // Disabling only gates the drive; the scan keeps its place.
      if (enable) begin
        segments_reg <= {7{POL}} ^ seg_on;
        dp_reg       <= POL ^ dp_on;
        anode_reg    <= {DIGITS{POL}} ^ anode_on;
      end else begin
        segments_reg <= {7{POL}};
        dp_reg       <= POL;
        anode_reg    <= {DIGITS{POL}};
      end
    end
  end

  assign segments = segments_reg;
  assign dp       = dp_reg;
  assign anode    = anode_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Two scanner instances (slow active-low, 1-cycle active-high) checked every
// cycle against a cycle-count based display model.
module tb_seven_seg_scanner;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;

  int          n_checks = 0;
  int          n_pass = 0;

  // Model state: edges since reset release and the snapshot contents.
  int          k_ref = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0;
  logic [11:0] exp_a, exp_b;

  logic [6:0]  glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .enable(enable), .segments(seg_a), .dp(dp_a), .anode(an_a)
  );

  seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(1), .ACTIVE_LOW(0), .BLANK_LEADING(1)) dut_b (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .enable(enable), .segments(seg_b), .dp(dp_b), .anode(an_b)
  );

  always #5 clk = ~clk;

  // Expected {segments, dp, anode} produced at the coming edge.
  function automatic logic [11:0] model(input int rd, input bit al, input bit rst, input bit en);
    logic [6:0]  s;
    logic        p;
    logic [3:0]  a;
    logic [15:0] upper;
    logic [3:0]  one;
    int          d;
    s = 7'h7F;
    p = 1'b1;
    a = 4'hF;
    if (!rst && en) begin
      d = (k_ref / rd) % D;
      one = 4'b0001;
      a = ~(one << d);
      p = ~m_dp[d];
      upper = m_value >> (4 * d);
      if (d > 0 && upper == 16'h0) s = 7'h7F;
      else s = glyph_tab[upper[3:0]];
    end
    if (!al) begin
      s = ~s;
      p = ~p;
      a = ~a;
    end
    return {s, p, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    exp_a = model(4, 1'b1, reset, enable);
    exp_b = model(1, 1'b0, reset, enable);
    if (reset) begin
      k_ref = 0;
      m_value = '0;
      m_dp = '0;
    end else begin
      k_ref++;
      if (load) begin
        m_value = value;
        m_dp = dp_in;
        $display("load value=%h dp=%b enable=%b", value, dp_in, enable);
      end
    end
    @(negedge clk);
    check("a_segments", 32'(seg_a), 32'(exp_a[11:5]));
    check("a_dp",       32'(dp_a),  32'(exp_a[4]));
    check("a_anode",    32'(an_a),  32'(exp_a[3:0]));
    check("b_segments", 32'(seg_b), 32'(exp_b[11:5]));
    check("b_dp",       32'(dp_b),  32'(exp_b[4]));
    check("b_anode",    32'(an_b),  32'(exp_b[3:0]));
  endtask

  task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset held, with load asserted to show it is ignored.
    value = 16'hBEEF;
    load = 1'b1;
    repeat (3) step();
    load = 1'b0;
    reset = 1'b0;

    load_pulse(16'h12AF, 4'b0000);
    repeat (24) step();

    load_pulse(16'h0030, 4'b0100);
    repeat (16) step();
    load_pulse(16'h0000, 4'b0000);
    repeat (16) step();

    // Snapshot hold: input changes without load are invisible.
    load_pulse(16'h0030, 4'b0100);
    value = 16'hFFFF;
    repeat (20) step();
    load_pulse(16'hFFFF, 4'b0000);
    repeat (8) step();

    // Enable dropped mid-scan.
    load_pulse(16'h12AF, 4'b1010);
    repeat (5) step();
    enable = 1'b0;
    repeat (6) step();
    enable = 1'b1;
    repeat (12) step();

    // Reset in the middle of a digit period.
    repeat (9) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();

    // Randomized traffic with frequent leading zeros.
    repeat (400) begin
      value  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in  = 4'($urandom);
      load   = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 9) != 0);
      reset  = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    load = 1'b0;
    enable = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
